register_file_2r1w: RTL and testbench
=====================================

Name: register_file_2r1w

Overview:
- Next-generation storage array for the fifo building blocks: one write port, two independent read ports.
- Writes are masked per lane.
- Reads are registered, with a valid flag per port and selectable read-during-write behaviour.
- A sequential clear engine zeroes the whole array without software looping.
- Serves as backing store for multi-reader FIFOs and small scratch register banks.

Parameters:
- DATA_WIDTH, 8: word width in bits; must be an integer multiple of LANE_WIDTH.
- ADDR_WIDTH, 2: address width; DEPTH = 2**ADDR_WIDTH entries.
- LANE_WIDTH, 8: bits per write-enable lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH.
- BYPASS, 1: 1 = write-first forwarding on same-cycle address match; 0 = read returns old contents.

Ports:
- clk  input  1  single clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- w_en  input  1  write request.
- w_addr  input  ADDR_WIDTH  write address.
- w_data  input  DATA_WIDTH  write data.
- w_be  input  NUM_LANES  lane enables; bit i covers w_data[i*LANE_WIDTH +: LANE_WIDTH].
- w_err  output  1  one-cycle pulse: write dropped because clear was busy.
- r_en_a  input  1  port A read request.
- r_addr_a  input  ADDR_WIDTH  port A read address.
- r_data_a  output  DATA_WIDTH  port A registered read data.
- r_valid_a  output  1  port A data valid.
- r_en_b, r_addr_b, r_data_b, r_valid_b: port B, identical to port A.
- clr_req  input  1  start a full-array clear.
- clr_busy  output  1  clear sweep in progress.

Behaviour:
- Reset values: r_data_a/b = 0, r_valid_a/b = 0, clr_busy = 0, w_err = 0, FSM = IDLE, sweep pointer = 0.
- Storage contents are not affected by reset.
- Write acceptance:
  - A write is accepted when w_en=1 and clr_busy=0.
  - Lanes with w_be[i]=1 update at the clock edge; lanes with w_be[i]=0 keep their value.
  - w_be = 0 with w_en=1 is accepted and changes nothing.
- Dropped write: w_en=1 while clr_busy=1 changes no storage; w_err=1 in the following cycle only.
- Read latency is 1 cycle:
  - r_en_x=1 at edge N → at edge N+1, r_data_x = entry at r_addr_x and r_valid_x=1.
  - r_en_x=0 → r_valid_x=0 next cycle; r_data_x holds its last value.
- Ports A and B are fully independent; the same address on both ports is legal.
- Read-during-write, same address, same cycle:
  - BYPASS=1: enabled lanes come from w_data, other lanes from storage.
  - BYPASS=0: pre-write contents are returned.
  - Applies to each port independently.
- Clear FSM, states IDLE and SWEEP:
  - IDLE, clr_req=1 → SWEEP; clr_busy=1 from the next cycle; pointer = 0.
  - SWEEP: each cycle writes all-zero to entry[pointer], all lanes, then pointer increments.
  - SWEEP ends after entry DEPTH-1 is written; then → IDLE and clr_busy=0 the following cycle.
  - clr_busy is high for exactly DEPTH cycles.
  - clr_req during SWEEP is ignored (no restart, no extension).
- Clear and bypass interaction: for read bypass, a sweep write counts as a full-lane write of zero. With BYPASS=1, reading the entry being cleared that cycle returns 0.
- Reads stay fully functional during SWEEP.
- Simultaneous w_en and clr_req in IDLE: the write is accepted, since clr_busy is still 0, and is later zeroed by the sweep.
- Reset during SWEEP: FSM → IDLE, clr_busy=0 next cycle. Entries already cleared stay 0; the remainder keep their old data.
- The pointer is ADDR_WIDTH bits wide and must not wrap into a second pass.

Test Plan:
- Lane-masked write: defaults. Write addr 1 = 0xA5 (w_be=1), then write addr 1 = 0x3C with w_be=0, then read A addr 1 → r_data_a=0xA5 one cycle after r_en_a, r_valid_a=1 for one cycle.
- Dual read:
  - Setup: DATA_WIDTH=16, LANE_WIDTH=8; addr 2 = 0x1234, addr 3 = 0xBEEF.
  - Stimulus: read A addr 2, B addr 3 in the same cycle.
  - Expected: 0x1234 / 0xBEEF next cycle.
  - Then write addr 2 = 0xFF00 with w_be=2'b10 → addr 2 reads 0xFF34.
- Bypass: addr 0 holds 0x11; write 0x22 to addr 0 while reading addr 0 on both ports → BYPASS=1 returns 0x22; BYPASS=0 returns 0x11, and a re-read returns 0x22.
- Clear:
  - Stimulus: fill all 4 entries nonzero; pulse clr_req.
  - clr_busy is high for exactly 4 cycles.
  - w_en issued during the sweep → w_err pulse, no update.
  - clr_req re-pulsed mid-sweep → no extension.
  - Afterwards all entries read 0.
- Reset mid-sweep:
  - Stimulus: entries = 0x0F; clr_req; assert reset after 2 sweep cycles.
  - Expected: clr_busy=0 and r_valid=0 next cycle; entries 0–1 read 0, entries 2–3 read 0x0F.

Source files
------------

// File: rtl/register_file_2r1w.sv
// Two-read, one-write register file with lane-masked writes, registered reads,
// optional write-first forwarding and a sequential whole-array clear engine.
//
// state | meaning
// IDLE  | normal operation, writes accepted, waiting for clr_req
// SWEEP | zeroing entry[ptr] each cycle, user writes dropped
module register_file_2r1w #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int LANE_WIDTH = 8,
  parameter int BYPASS     = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               w_en,
  input  logic [ADDR_WIDTH-1:0]              w_addr,
  input  logic [DATA_WIDTH-1:0]              w_data,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0]   w_be,
  output logic                               w_err,
  input  logic                               r_en_a,
  input  logic [ADDR_WIDTH-1:0]              r_addr_a,
  output logic [DATA_WIDTH-1:0]              r_data_a,
  output logic                               r_valid_a,
  input  logic                               r_en_b,
  input  logic [ADDR_WIDTH-1:0]              r_addr_b,
  output logic [DATA_WIDTH-1:0]              r_data_b,
  output logic                               r_valid_b,
  input  logic                               clr_req,
  output logic                               clr_busy
);

  localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wr_acc;
  logic                    sweep_we;
  logic [DATA_WIDTH-1:0]   fwd_a;
  logic [DATA_WIDTH-1:0]   fwd_b;

  assign wr_acc   = w_en && !clr_busy;
  // A reset edge must not clear one more entry.
  assign sweep_we = (state == SWEEP) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      clr_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= SWEEP;
            ptr      <= '0;
            clr_busy <= 1'b1;
          end
        end
        SWEEP: begin
          if (ptr == LAST_ADDR) begin
            state    <= IDLE;
            ptr      <= '0;
            clr_busy <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          ptr      <= '0;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_err <= 1'b0;
    end else begin
      w_err <= w_en && clr_busy;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[ptr] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (w_be[i]) begin
          mem[w_addr][i*LANE_WIDTH +: LANE_WIDTH] <= w_data[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // Sweep writes forward as a full-lane zero write.
  always_comb begin
    fwd_a = mem[r_addr_a];
    fwd_b = mem[r_addr_b];
    if (BYPASS != 0) begin
      if (sweep_we) begin
        if (ptr == r_addr_a) fwd_a = '0;
        if (ptr == r_addr_b) fwd_b = '0;
      end else if (wr_acc) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (w_be[i] && (w_addr == r_addr_a)) begin
            fwd_a[i*LANE_WIDTH +: LANE_WIDTH] = w_data[i*LANE_WIDTH +: LANE_WIDTH];
          end
          if (w_be[i] && (w_addr == r_addr_b)) begin
            fwd_b[i*LANE_WIDTH +: LANE_WIDTH] = w_data[i*LANE_WIDTH +: LANE_WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_a  <= '0;
      r_valid_a <= 1'b0;
      r_data_b  <= '0;
      r_valid_b <= 1'b0;
    end else begin
      r_valid_a <= r_en_a;
      r_valid_b <= r_en_b;
      if (r_en_a) r_data_a <= fwd_a;
      if (r_en_b) r_data_b <= fwd_b;
    end
  end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Drives one command stream into an 8-bit write-first instance and a 16-bit
// read-old instance; a per-cycle model queues expectations checked at negedge.
module tb_register_file_2r1w;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_en;
  logic [1:0]  w_addr;
  logic [15:0] w_data;
  logic [1:0]  w_be;
  logic        r_en_a, r_en_b;
  logic [1:0]  r_addr_a, r_addr_b;
  logic        clr_req;

  logic        w_err8, r_valid_a8, r_valid_b8, clr_busy8;
  logic [7:0]  r_data_a8, r_data_b8;
  logic        w_err16, r_valid_a16, r_valid_b16, clr_busy16;
  logic [15:0] r_data_a16, r_data_b16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  register_file_2r1w #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .LANE_WIDTH(8), .BYPASS(1)) u_dut8 (
    .clk(clk), .reset(reset),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data[7:0]), .w_be(w_be[0:0]), .w_err(w_err8),
    .r_en_a(r_en_a), .r_addr_a(r_addr_a), .r_data_a(r_data_a8), .r_valid_a(r_valid_a8),
    .r_en_b(r_en_b), .r_addr_b(r_addr_b), .r_data_b(r_data_b8), .r_valid_b(r_valid_b8),
    .clr_req(clr_req), .clr_busy(clr_busy8)
  );

  register_file_2r1w #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .LANE_WIDTH(8), .BYPASS(0)) u_dut16 (
    .clk(clk), .reset(reset),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_be(w_be), .w_err(w_err16),
    .r_en_a(r_en_a), .r_addr_a(r_addr_a), .r_data_a(r_data_a16), .r_valid_a(r_valid_a16),
    .r_en_b(r_en_b), .r_addr_b(r_addr_b), .r_data_b(r_data_b16), .r_valid_b(r_valid_b16),
    .clr_req(clr_req), .clr_busy(clr_busy16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        busy;
    logic        err;
    logic        va;
    logic        vb;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [15:0] a16;
    logic [15:0] b16;
  } exp_t;

  exp_t exp_q[$];

  logic [7:0]  mem8  [4];
  logic [15:0] mem16 [4];
  logic        m_busy = 1'b0;
  logic        m_err = 1'b0;
  logic [1:0]  m_ptr = 2'd0;
  exp_t        m_out = '0;

  // Write-first view for the BYPASS=1 instance, using state before this edge.
  function automatic logic [7:0] fwd8(input logic [1:0] a);
    if (m_busy && m_ptr == a) return 8'h00;
    if (!m_busy && w_en && w_be[0] && w_addr == a) return w_data[7:0];
    return mem8[a];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0;
      m_ptr  = 2'd0;
      m_out  = '0;
    end else begin
      m_out.err = w_en && m_busy;
      m_out.va  = r_en_a;
      m_out.vb  = r_en_b;
      if (r_en_a) begin
        m_out.a8  = fwd8(r_addr_a);
        m_out.a16 = mem16[r_addr_a];
      end
      if (r_en_b) begin
        m_out.b8  = fwd8(r_addr_b);
        m_out.b16 = mem16[r_addr_b];
      end
      if (m_busy) begin
        mem8[m_ptr]  = 8'h00;
        mem16[m_ptr] = 16'h0000;
        if (m_ptr == 2'd3) m_busy = 1'b0;
        m_ptr = m_ptr + 2'd1;
      end else begin
        if (w_en && w_be[0]) begin
          mem8[w_addr]       = w_data[7:0];
          mem16[w_addr][7:0] = w_data[7:0];
        end
        if (w_en && w_be[1]) mem16[w_addr][15:8] = w_data[15:8];
        if (clr_req) begin
          m_busy = 1'b1;
          m_ptr  = 2'd0;
        end
      end
    end
    m_out.busy = m_busy;
    exp_q.push_back(m_out);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("busy8",    32'(clr_busy8),   32'(e.busy));
      check("busy16",   32'(clr_busy16),  32'(e.busy));
      check("w_err8",   32'(w_err8),      32'(e.err));
      check("w_err16",  32'(w_err16),     32'(e.err));
      check("valid_a8", 32'(r_valid_a8),  32'(e.va));
      check("valid_b8", 32'(r_valid_b8),  32'(e.vb));
      check("valid_a16",32'(r_valid_a16), 32'(e.va));
      check("valid_b16",32'(r_valid_b16), 32'(e.vb));
      check("data_a8",  32'(r_data_a8),   32'(e.a8));
      check("data_b8",  32'(r_data_b8),   32'(e.b8));
      check("data_a16", 32'(r_data_a16),  32'(e.a16));
      check("data_b16", 32'(r_data_b16),  32'(e.b16));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    w_en = 1'b0; r_en_a = 1'b0; r_en_b = 1'b0; clr_req = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic [1:0] be);
    w_en = 1'b1; w_addr = a; w_data = d; w_be = be;
    step();
  endtask

  task automatic rd(input logic [1:0] a, input logic [1:0] b);
    r_en_a = 1'b1; r_addr_a = a; r_en_b = 1'b1; r_addr_b = b;
    step();
  endtask

  initial begin
    reset = 1'b1;
    w_en = 1'b0; w_addr = '0; w_data = '0; w_be = '0;
    r_en_a = 1'b0; r_addr_a = '0; r_en_b = 1'b0; r_addr_b = '0; clr_req = 1'b0;
    step(); step();
    reset = 1'b0;

    wr(2'd0, 16'h0011, 2'b11);
    wr(2'd1, 16'h7700, 2'b11);
    wr(2'd2, 16'h1234, 2'b11);
    wr(2'd3, 16'hBEEF, 2'b11);

    // lane mask: low lane only, then an empty mask
    wr(2'd1, 16'h00A5, 2'b01);
    wr(2'd1, 16'h003C, 2'b00);
    r_en_a = 1'b1; r_addr_a = 2'd1;
    step();
    step();

    rd(2'd2, 2'd3);
    wr(2'd2, 16'hFF00, 2'b10);
    rd(2'd2, 2'd2);

    // same-cycle read/write on address 0
    w_en = 1'b1; w_addr = 2'd0; w_data = 16'h0022; w_be = 2'b11;
    r_en_a = 1'b1; r_addr_a = 2'd0; r_en_b = 1'b1; r_addr_b = 2'd0;
    step();
    rd(2'd0, 2'd0);
    w_en = 1'b1; w_addr = 2'd0; w_data = 16'h9999; w_be = 2'b00;
    r_en_a = 1'b1; r_addr_a = 2'd0; r_en_b = 1'b1; r_addr_b = 2'd1;
    step();

    // clear with a coincident write, a dropped write and a re-request
    w_en = 1'b1; w_addr = 2'd3; w_data = 16'h5A5A; w_be = 2'b11; clr_req = 1'b1;
    step();
    w_en = 1'b1; w_addr = 2'd1; w_data = 16'hDEAD; w_be = 2'b11;
    r_en_a = 1'b1; r_addr_a = 2'd0; r_en_b = 1'b1; r_addr_b = 2'd1;
    step();
    clr_req = 1'b1; r_en_a = 1'b1; r_addr_a = 2'd1; r_en_b = 1'b1; r_addr_b = 2'd3;
    step();
    step();
    step();
    step();
    rd(2'd0, 2'd1);
    rd(2'd2, 2'd3);

    // reset in the middle of a sweep
    for (int i = 0; i < 4; i++) wr(2'(i), 16'h000F, 2'b11);
    clr_req = 1'b1;
    step();
    step();
    r_en_a = 1'b1; r_addr_a = 2'd3;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    rd(2'd0, 2'd1);
    rd(2'd2, 2'd3);
    step();
    step();

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
